// File: rtl/line_render_scheduler.sv
// Schedules per-line rendering into the two halves of the scan-out line buffer.
// Primes both halves, then refills each half as scan-out releases it, and flags late lines.
module line_render_scheduler #(
  parameter int unsigned LINES     = 240,
  parameter int unsigned BUF1_BASE = 640,
  parameter int unsigned LINE_W    = 9
) (
  input  logic              sys_clk_i,
  input  logic              reset_i,
  input  logic              mode_changed_i,
  input  logic              frame_start_i,
  input  logic              render_start_i,
  input  logic              scanline_start_i,
  input  logic              pixel_scale_i,
  output logic              render_req_o,
  output logic [LINE_W-1:0] render_line_o,
  output logic [10:0]       render_base_o,
  input  logic              render_done_i,
  output logic              frame_active_o,
  output logic              underrun_o,
  output logic [7:0]        underrun_count_o
);

  typedef enum logic [2:0] {StIdle, StPrime, StWait, StRender, StDone} state_e;

  localparam logic [LINE_W-1:0] LinesW = LINE_W'(LINES);
  localparam logic [10:0]       BaseB  = 11'(BUF1_BASE);

  state_e            state_q, state_d;
  logic              scl_q, scl_d;
  logic [LINE_W-1:0] line_idx_q, line_idx_d;
  logic [LINE_W-1:0] cur_q, cur_d;
  logic [9:0]        sl_cnt_q, sl_cnt_d;
  logic              pending_q, pending_d;
  logic              underrun_q, underrun_d;
  logic [7:0]        ucnt_q, ucnt_d;

  logic busy, counting, cnt_inc, slot, done, abort;

  assign busy     = (state_q == StPrime) || (state_q == StRender);
  assign counting = busy || (state_q == StWait);
  assign cnt_inc  = counting && scanline_start_i && (sl_cnt_q != 10'h3ff);
  // sl_cnt_q is the pre-increment value, so this is (new_count - 1) mod H == 0 with new_count > 1.
  assign slot     = cnt_inc && (sl_cnt_q != '0) &&
                    (scl_q ? (sl_cnt_q[1:0] == 2'b00) : !sl_cnt_q[0]);
  assign done     = busy && render_done_i;
  assign abort    = frame_start_i || mode_changed_i;

  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      scl_q      <= 1'b0;
      line_idx_q <= '0;
      cur_q      <= '0;
      sl_cnt_q   <= '0;
      pending_q  <= 1'b0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      scl_q      <= scl_d;
      line_idx_q <= line_idx_d;
      cur_q      <= cur_d;
      sl_cnt_q   <= sl_cnt_d;
      pending_q  <= pending_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    scl_d      = scl_q;
    line_idx_d = line_idx_q;
    cur_d      = cur_q;
    sl_cnt_d   = cnt_inc ? sl_cnt_q + 10'd1 : sl_cnt_q;
    pending_d  = pending_q;
    underrun_d = underrun_q;
    ucnt_d     = ucnt_q;
    if (abort) begin
      state_d   = StIdle;
      sl_cnt_d  = sl_cnt_q;
      pending_d = 1'b0;
      if (frame_start_i) begin
        underrun_d = 1'b0;
        ucnt_d     = '0;
      end
    end else if (state_q == StIdle) begin
      if (render_start_i) begin
        scl_d      = pixel_scale_i;
        sl_cnt_d   = '0;
        line_idx_d = '0;
        cur_d      = '0;
        pending_d  = 1'b0;
        state_d    = StPrime;
      end
    end else begin
      // The done is resolved first; a coincident slot then sees the post-done state.
      if (done) begin
        line_idx_d = cur_q + 1'b1;
        if (cur_q == '0) begin
          if (LINES == 1) state_d = StDone;
          else            cur_d   = line_idx_d;
        end else if (pending_q) begin
          pending_d = 1'b0;
          if (line_idx_d < LinesW) begin
            cur_d   = line_idx_d;
            state_d = StRender;
          end else begin
            state_d = StDone;
          end
        end else begin
          state_d = StWait;
        end
      end
      if (slot) begin
        unique case (state_d)
          StWait: begin
            if (line_idx_d < LinesW) begin
              cur_d   = line_idx_d;
              state_d = StRender;
            end else begin
              state_d = StDone;
            end
          end
          StPrime, StRender: begin
            underrun_d = 1'b1;
            pending_d  = 1'b1;
            if (ucnt_q != 8'hff) ucnt_d = ucnt_q + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    render_req_o     = busy;
    render_line_o    = cur_q;
    render_base_o    = cur_q[0] ? BaseB : 11'd0;
    frame_active_o   = counting;
    underrun_o       = underrun_q;
    underrun_count_o = ucnt_q;
  end

endmodule

// File: tb/tb_line_render_scheduler.sv
// Bench for line_render_scheduler: a behavioural model predicts every line issue and the
// frame/underrun status; a monitor compares them against the DUT as they appear.
module tb_line_render_scheduler;
  localparam int LINES = 4;
  localparam int BUF1  = 640;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode_changed = 1'b0, frame_start = 1'b0, render_start = 1'b0, pixel_scale = 1'b0;
  logic scanline_start, render_done;
  logic render_req, frame_active, underrun;
  logic [8:0]  render_line;
  logic [10:0] render_base;
  logic [7:0]  underrun_count;

  logic sl_gen = 1'b0, man_sl = 1'b0, rd_gen = 1'b0, man_done = 1'b0;
  assign scanline_start = sl_gen | man_sl;
  assign render_done    = rd_gen | man_done;

  always #5 clk = ~clk;

  line_render_scheduler #(.LINES(LINES), .BUF1_BASE(BUF1), .LINE_W(9)) dut (
    .sys_clk_i        (clk),
    .reset_i          (rst),
    .mode_changed_i   (mode_changed),
    .frame_start_i    (frame_start),
    .render_start_i   (render_start),
    .scanline_start_i (scanline_start),
    .pixel_scale_i    (pixel_scale),
    .render_req_o     (render_req),
    .render_line_o    (render_line),
    .render_base_o    (render_base),
    .render_done_i    (render_done),
    .frame_active_o   (frame_active),
    .underrun_o       (underrun),
    .underrun_count_o (underrun_count)
  );

  typedef struct {int line; int base; int cyc;} iss_t;
  iss_t sb[$];
  int n_cmp = 0, n_err = 0, cyc = 0, n_iss = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: tracks the outstanding line, the next line owed, and the slot count.
  bit m_on = 0, m_fin = 0, m_busy = 0, m_owed = 0, m_scl = 0, m_ur = 0;
  int m_cur = 0, m_next = 0, m_sl = 0, m_uc = 0;

  function automatic void m_issue(input int n);
    iss_t e;
    m_busy = 1;
    m_cur  = n;
    e.line = n;
    e.base = (n % 2 == 1) ? BUF1 : 0;
    e.cyc  = cyc;
    sb.push_back(e);
  endfunction

  initial forever begin
    bit slot;
    int h;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_on = 0; m_fin = 0; m_busy = 0; m_owed = 0; m_scl = 0; m_ur = 0;
      m_cur = 0; m_next = 0; m_sl = 0; m_uc = 0;
      sb.delete();
    end else begin
      cyc++;
      if (frame_start || mode_changed) begin
        m_on = 0; m_fin = 0; m_busy = 0; m_owed = 0;
        if (frame_start) begin m_ur = 0; m_uc = 0; end
      end else if (!m_on) begin
        if (render_start) begin
          m_on = 1; m_fin = 0; m_scl = pixel_scale; m_sl = 0; m_next = 0; m_owed = 0;
          m_issue(0);
        end
      end else if (!m_fin) begin
        slot = 0;
        if (scanline_start && m_sl < 1023) begin
          m_sl++;
          h = m_scl ? 4 : 2;
          slot = (m_sl > 1) && ((m_sl - 1) % h == 0);
        end
        if (m_busy && render_done) begin
          m_busy = 0;
          m_next = m_cur + 1;
          if (m_cur == 0) begin
            if (LINES == 1) m_fin = 1; else m_issue(1);
          end else if (m_owed) begin
            m_owed = 0;
            if (m_next < LINES) m_issue(m_next); else m_fin = 1;
          end
        end
        if (slot && !m_fin) begin
          if (m_busy) begin
            m_ur = 1; m_owed = 1;
            if (m_uc < 255) m_uc++;
          end else if (m_next < LINES) m_issue(m_next);
          else m_fin = 1;
        end
      end
    end
  end

  // Monitor: status every cycle, and one scoreboard pop per new request seen.
  initial begin
    bit prev_req = 0;
    int prev_line = 0;
    iss_t e;
    logic [10:0] exp_st;
    forever begin
      @(posedge clk);
      #1;
      if (rst) prev_req = 0;
      else begin
        exp_st = {m_busy, m_on && !m_fin, m_ur, 8'(m_uc)};
        chk("status{req,active,underrun,count}",
            {render_req, frame_active, underrun, underrun_count}, exp_st);
        if (render_req && (!prev_req || int'(render_line) != prev_line)) begin
          n_iss++;
          if (sb.size() == 0) chk("unexpected issue line", render_line, -1);
          else begin
            e = sb.pop_front();
            chk("issue line", render_line, e.line);
            chk("issue base", render_base, e.base);
            chk("issue cycle", cyc, e.cyc);
          end
        end
        prev_req  = render_req;
        prev_line = int'(render_line);
      end
    end
  end

  // Renderer: answers each request with a done pulse rend_lat cycles later.
  bit rend_en = 0, r_busy = 0;
  int rend_lat = 3, r_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (rst || !rend_en) begin rd_gen = 0; r_busy = 0; end
    else begin
      if (rd_gen) begin rd_gen = 0; r_busy = 0; end
      else if (r_busy) begin
        if (r_cnt <= 1) rd_gen = 1; else r_cnt--;
      end
      if (!r_busy && !rd_gen && render_req) begin r_busy = 1; r_cnt = rend_lat; end
    end
  end

  // Scanline generator.
  bit sl_en = 0;
  int sl_period = 20, sl_ctr = 0;
  initial forever begin
    @(negedge clk);
    if (!sl_en) sl_gen = 0;
    else if (sl_ctr == 0) begin sl_gen = 1; sl_ctr = sl_period - 1; end
    else begin sl_gen = 0; sl_ctr--; end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; sl_en = 0; rend_en = 0; man_sl = 0; man_done = 0;
    tick(2);
    rst = 0;
  endtask

  task automatic start_frame(input bit scale, input int lat, input int period);
    chk("scoreboard drained", sb.size(), 0);
    @(negedge clk); frame_start = 1;
    @(negedge clk); frame_start = 0;
    pixel_scale = scale; rend_lat = lat; sl_period = period; rend_en = 1;
    @(negedge clk); render_start = 1; sl_ctr = period - 1; sl_en = 1; n_iss = 0;
    @(negedge clk); render_start = 0;
  endtask

  task automatic pulse_mode();
    @(negedge clk); mode_changed = 1;
    @(negedge clk); mode_changed = 0;
  endtask

  task automatic pulse_done();
    @(negedge clk); man_done = 1;
    @(negedge clk); man_done = 0;
  endtask

  task automatic pulse_sl();
    @(negedge clk); man_sl = 1;
    @(negedge clk); man_sl = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    int waited;
    tick(2);
    rst = 0;
    @(posedge clk); #1;
    chk("reset req", render_req, 0);
    chk("reset active", frame_active, 0);
    chk("reset count", underrun_count, 0);

    // Basic frame.
    do_reset();
    start_frame(0, 3, 20);
    tick(200);
    chk("basic issues", n_iss, 4);
    chk("basic active end", frame_active, 0);
    chk("basic count", underrun_count, 0);

    // Scaled.
    do_reset();
    start_frame(1, 3, 20);
    tick(320);
    chk("scaled issues", n_iss, 4);
    chk("scaled active end", frame_active, 0);

    // Slow renderer.
    do_reset();
    start_frame(0, 50, 20);
    tick(420);
    chk("slow underrun", underrun, 1);
    chk("slow issues", n_iss, 4);
    chk("slow count", underrun_count, 4);

    // Abort while a request is outstanding.
    do_reset();
    start_frame(0, 50, 20);
    tick(150);
    waited = 0;
    while (!render_req && waited < 100) begin @(negedge clk); waited++; end
    chk("abort req seen", render_req, 1);
    mode_changed = 1;
    @(posedge clk); #1;
    chk("abort req drop", render_req, 0);
    chk("abort active drop", frame_active, 0);
    chk("abort keeps underrun", underrun, 1);
    @(negedge clk); mode_changed = 0;
    tick(80);
    chk("late done ignored", render_req, 0);
    @(negedge clk); frame_start = 1;
    @(posedge clk); #1;
    chk("frame_start clears underrun", underrun, 0);
    chk("frame_start clears count", underrun_count, 0);
    @(negedge clk); frame_start = 0;

    // Coincident done and slot, then async reset mid-render.
    do_reset();
    pixel_scale = 0;
    @(negedge clk); render_start = 1;
    @(negedge clk); render_start = 0;
    tick(2); pulse_done();
    tick(2); pulse_done();
    repeat (4) begin pulse_sl(); tick(3); end
    @(negedge clk); man_done = 1; man_sl = 1;
    @(posedge clk); #1;
    chk("coincide line", render_line, 3);
    chk("coincide req", render_req, 1);
    chk("coincide no underrun", underrun, 0);
    @(negedge clk); man_done = 0; man_sl = 0;
    tick(2);
    #2 rst = 1;
    #1;
    chk("async rst req", render_req, 0);
    chk("async rst line", render_line, 0);
    chk("async rst base", render_base, 0);
    chk("async rst active", frame_active, 0);
    @(negedge clk); @(negedge clk); rst = 0;

    // Randomised frames, some aborted by mode_changed; each start aborts the previous one.
    do_reset();
    for (int f = 0; f < 8; f++) begin
      start_frame(1'($urandom_range(0, 1)), $urandom_range(1, 60), $urandom_range(8, 30));
      run = $urandom_range(60, 500);
      if ($urandom_range(0, 2) == 0) begin
        tick(run / 2);
        pulse_mode();
        tick(run / 2);
      end else begin
        tick(run);
      end
    end
    tick(5);
    chk("final drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
